// File: rtl/ipparser.sv
// ipparser: receive-side IPv4/UDP header parser. It checks the source-MAC and
// ethertype words and the 20-byte IPv4 header, including the header checksum.
// It latches the header fields and forwards the payload of accepted packets
// through one register stage. Rejected or short frames are discarded up to
// TLAST and counted.
module ipparser #(
   parameter logic [15:0] IPv4_PROTO = 16'h0800,
   parameter logic [7:0]  SUB_PROTO  = 8'd17
) (
   input  logic        S_AXI_ACLK,
   input  logic        S_AXI_ARESET,
   input  logic [31:0] i_ip_addr,
   input  logic        S_AXI_TVALID,
   output logic        S_AXI_TREADY,
   input  logic [31:0] S_AXI_TDATA,
   input  logic        S_AXI_TLAST,
   output logic        M_AXI_TVALID,
   input  logic        M_AXI_TREADY,
   output logic [31:0] M_AXI_TDATA,
   output logic        M_AXI_TLAST,
   output logic        o_hdr_valid,
   output logic [47:0] o_enet_src,
   output logic [31:0] o_ip_src,
   output logic [15:0] o_ip_len,
   output logic [15:0] o_pkt_id,
   output logic [15:0] o_drop_count
);

   typedef enum logic [1:0] {ST_HDR, ST_FWD, ST_DROP} state_t;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_cnt, w_cnt_nxt;
   logic        r_ok;
   logic [15:0] r_csum;
   logic [47:0] r_sh_mac;
   logic [15:0] r_sh_len, r_sh_id;
   logic [31:0] r_sh_src;
   logic        r_m_valid, r_m_last, r_hdr_valid;
   logic [31:0] r_m_data;
   logic [47:0] r_enet_src;
   logic [31:0] r_ip_src;
   logic [15:0] r_ip_len, r_pkt_id, r_drop_cnt;

   logic        w_s_ready, w_accept, w_word_ok, w_ok_so_far;
   logic        w_hdr_accept, w_drop;
   logic [15:0] w_csum_nxt;

   // One's-complement add of both halves of a word, folded twice back to 16 bits.
   function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [31:0] d);
      logic [17:0] s;
      logic [16:0] t;
      s = {2'b00, acc} + {2'b00, d[31:16]} + {2'b00, d[15:0]};
      t = {1'b0, s[15:0]} + {15'b0, s[17:16]};
      return t[15:0] + {15'b0, t[16]};
   endfunction

   // In FWD, input is accepted only when the output register can take the word.
   assign w_s_ready  = !S_AXI_ARESET &&
                       ((r_state != ST_FWD) || !r_m_valid || M_AXI_TREADY);
   assign w_accept   = S_AXI_TVALID && w_s_ready;
   // The accumulator restarts at w2, where the IPv4 header begins.
   assign w_csum_nxt = csum_add((r_cnt == 3'd2) ? 16'h0000 : r_csum, S_AXI_TDATA);

   // Per-word header check for the word currently presented.
   always_comb begin
      w_word_ok = 1'b1;
      case (r_cnt)
         3'd1: w_word_ok = (S_AXI_TDATA[15:0] == IPv4_PROTO);
         3'd2: w_word_ok = (S_AXI_TDATA[31:24] == 8'h45);
         3'd3: w_word_ok = (S_AXI_TDATA[13:0] == 14'd0);
         3'd4: w_word_ok = (S_AXI_TDATA[23:16] == SUB_PROTO);
         3'd6: w_word_ok = ((S_AXI_TDATA == i_ip_addr) || (S_AXI_TDATA == 32'hffff_ffff)) &&
                           (w_csum_nxt == 16'hffff);
         default: w_word_ok = 1'b1;
      endcase
      w_ok_so_far = ((r_cnt == 3'd0) ? 1'b1 : r_ok) && w_word_ok;
   end

   // Next-state logic: header walk, accept/drop decision, discard to TLAST.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_hdr_accept = 1'b0;
      w_drop       = 1'b0;
      case (r_state)
         ST_HDR: begin
            if (w_accept) begin
               if (S_AXI_TLAST) begin
                  w_cnt_nxt = 3'd0;
                  w_drop    = 1'b1;
               end else if (r_cnt == 3'd6) begin
                  w_cnt_nxt = 3'd0;
                  if (w_ok_so_far) begin
                     w_state_nxt  = ST_FWD;
                     w_hdr_accept = 1'b1;
                  end else begin
                     w_state_nxt = ST_DROP;
                     w_drop      = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 3'd1;
               end
            end
         end
         ST_FWD, ST_DROP: begin
            if (w_accept && S_AXI_TLAST) w_state_nxt = ST_HDR;
         end
         default: w_state_nxt = ST_HDR;
      endcase
   end

   // State register, word counter, running check flag and checksum accumulator.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (S_AXI_ARESET) begin
         r_state <= ST_HDR;
         r_cnt   <= 3'd0;
         r_ok    <= 1'b0;
         r_csum  <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept && (r_state == ST_HDR)) begin
            r_ok <= w_ok_so_far;
            if (r_cnt >= 3'd2) r_csum <= w_csum_nxt;
         end
      end
   end

   // Shadow capture of header fields while the header streams in.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_sh_mac <= 48'd0;
         r_sh_len <= 16'd0;
         r_sh_id  <= 16'd0;
         r_sh_src <= 32'd0;
      end else if (w_accept && (r_state == ST_HDR)) begin
         case (r_cnt)
            3'd0: r_sh_mac[47:16] <= S_AXI_TDATA;
            3'd1: r_sh_mac[15:0]  <= S_AXI_TDATA[31:16];
            3'd2: r_sh_len        <= S_AXI_TDATA[15:0];
            3'd3: r_sh_id         <= S_AXI_TDATA[31:16];
            3'd5: r_sh_src        <= S_AXI_TDATA;
            default: ;
         endcase
      end
   end

   // Published header fields, acceptance pulse and saturating drop counter.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_hdr_valid <= 1'b0;
         r_enet_src  <= 48'd0;
         r_ip_src    <= 32'd0;
         r_ip_len    <= 16'd0;
         r_pkt_id    <= 16'd0;
         r_drop_cnt  <= 16'd0;
      end else begin
         r_hdr_valid <= w_hdr_accept;
         if (w_hdr_accept) begin
            r_enet_src <= r_sh_mac;
            r_ip_src   <= r_sh_src;
            r_ip_len   <= r_sh_len;
            r_pkt_id   <= r_sh_id;
         end
         if (w_drop && (r_drop_cnt != 16'hffff)) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   // Payload output register; it drains independently of the parser state.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_m_valid <= 1'b0;
         r_m_data  <= 32'd0;
         r_m_last  <= 1'b0;
      end else begin
         if (r_m_valid && M_AXI_TREADY) r_m_valid <= 1'b0;
         if ((r_state == ST_FWD) && w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= S_AXI_TDATA;
            r_m_last  <= S_AXI_TLAST;
         end
      end
   end

   assign S_AXI_TREADY = w_s_ready;
   assign M_AXI_TVALID = r_m_valid;
   assign M_AXI_TDATA  = r_m_data;
   assign M_AXI_TLAST  = r_m_last;
   assign o_hdr_valid  = r_hdr_valid;
   assign o_enet_src   = r_enet_src;
   assign o_ip_src     = r_ip_src;
   assign o_ip_len     = r_ip_len;
   assign o_pkt_id     = r_pkt_id;
   assign o_drop_count = r_drop_cnt;

endmodule

// File: tb/tb_ipparser.sv
// tb_ipparser: directed self-checking bench for ipparser.
module tb_ipparser;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ip_addr = 32'hC0A8_0002;
   logic        s_valid, s_ready, s_last;
   logic [31:0] s_data;
   logic        m_valid, m_ready, m_last;
   logic [31:0] m_data;
   logic        hdr_valid;
   logic [47:0] enet_src;
   logic [31:0] ip_src;
   logic [15:0] ip_len, pkt_id, drop_count;

   int          n_checks = 0;
   int          n_errors = 0;
   int          hdr_cnt = 0;
   int          hdr_base;
   int          stall_viol = 0;
   int          ready_viol = 0;
   logic        hv_w6;
   logic        bp_en = 1'b0;
   int          bp_idx = 0;
   logic [32:0] rx_q[$];
   logic [31:0] pkt[10];
   logic        prev_stall = 1'b0;
   logic [32:0] prev_beat = '0;

   ipparser dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .i_ip_addr    (ip_addr),
      .S_AXI_TVALID (s_valid),
      .S_AXI_TREADY (s_ready),
      .S_AXI_TDATA  (s_data),
      .S_AXI_TLAST  (s_last),
      .M_AXI_TVALID (m_valid),
      .M_AXI_TREADY (m_ready),
      .M_AXI_TDATA  (m_data),
      .M_AXI_TLAST  (m_last),
      .o_hdr_valid  (hdr_valid),
      .o_enet_src   (enet_src),
      .o_ip_src     (ip_src),
      .o_ip_len     (ip_len),
      .o_pkt_id     (pkt_id),
      .o_drop_count (drop_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Downstream ready: constant 1, or the repeating 1,0,0,1 pattern, driven away from the edge.
   initial m_ready = 1'b1;
   always @(posedge clk) begin
      #2;
      if (bp_en) begin
         m_ready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
         bp_idx  = bp_idx + 1;
      end else begin
         m_ready = 1'b1;
      end
   end

   // Output monitor: collects delivered beats, header pulses and handshake rule violations.
   always @(posedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (hdr_valid) hdr_cnt <= hdr_cnt + 1;
         if (m_valid && m_ready) rx_q.push_back({m_last, m_data});
         if (prev_stall && !(m_valid && ({m_last, m_data} == prev_beat))) stall_viol <= stall_viol + 1;
         if (!s_ready && !(m_valid && !m_ready)) ready_viol <= ready_viol + 1;
         prev_stall <= m_valid && !m_ready;
         prev_beat  <= {m_last, m_data};
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_p();
      pkt[0] = 32'h0200_0000; pkt[1] = 32'h0001_0800;
      pkt[2] = 32'h4500_0020; pkt[3] = 32'h0001_0000; pkt[4] = 32'h8011_B978;
      pkt[5] = 32'hC0A8_0001; pkt[6] = 32'hC0A8_0002;
      pkt[7] = 32'hAAAA_0001; pkt[8] = 32'hAAAA_0002; pkt[9] = 32'hAAAA_0003;
   endtask

   // Sends pkt[0..n-1] starting at a falling edge; TLAST on the final word if end_last.
   task automatic send_frame(input int n, input bit end_last);
      hv_w6 = 1'b0;
      for (int i = 0; i < n; i++) begin
         int t;
         s_valid = 1'b1;
         s_data  = pkt[i];
         s_last  = end_last && (i == n - 1);
         t = 0;
         while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) check("s_ready_timeout", {63'd0, s_ready}, 64'd1);
         @(negedge clk);
         if (i == 6) hv_w6 = hdr_valid;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_payload(input string tag);
      logic [32:0] b;
      check({tag, "_beats"}, rx_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         b = (i < rx_q.size()) ? rx_q[i] : 33'h0;
         check({tag, "_beat"}, {31'd0, b}, {31'd0, (i == 2), 32'hAAAA_0001 + i});
      end
   endtask

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      load_p();
      idle(3);
      check("rst_s_ready", {63'd0, s_ready}, 64'd0);
      check("rst_m_valid", {63'd0, m_valid}, 64'd0);
      check("rst_m_data", {32'd0, m_data}, 64'd0);
      check("rst_hdr_valid", {63'd0, hdr_valid}, 64'd0);
      check("rst_enet_src", {16'd0, enet_src}, 64'd0);
      check("rst_drop", {48'd0, drop_count}, 64'd0);
      rst = 1'b0;
      idle(2);

      // Clean accept.
      rx_q.delete(); hdr_base = hdr_cnt;
      send_frame(10, 1'b1); idle(6);
      check("clean_hv_after_w6", {63'd0, hv_w6}, 64'd1);
      check("clean_hdr_pulses", hdr_cnt - hdr_base, 1);
      check("clean_enet_src", {16'd0, enet_src}, 64'h0200_0000_0001);
      check("clean_ip_src", {32'd0, ip_src}, 64'hC0A8_0001);
      check("clean_ip_len", {48'd0, ip_len}, 64'h0020);
      check("clean_pkt_id", {48'd0, pkt_id}, 64'h0001);
      check_payload("clean");
      check("clean_drop", {48'd0, drop_count}, 64'd0);

      // Bad checksum, then a clean packet back to back.
      rx_q.delete(); hdr_base = hdr_cnt;
      pkt[4] = 32'h8011_B979; send_frame(10, 1'b1);
      load_p(); send_frame(10, 1'b1); idle(6);
      check("badcs_hdr_pulses", hdr_cnt - hdr_base, 1);
      check_payload("badcs_next");
      check("badcs_drop", {48'd0, drop_count}, 64'd1);

      // Filter drops: wrong destination, wrong protocol, wrong ethertype.
      rx_q.delete(); hdr_base = hdr_cnt;
      load_p(); pkt[6] = 32'hC0A8_0003; pkt[4] = 32'h8011_B977; send_frame(10, 1'b1);
      load_p(); pkt[4] = 32'h8006_B983; send_frame(10, 1'b1);
      load_p(); pkt[1] = 32'h0001_86DD; send_frame(10, 1'b1);
      idle(6);
      check("filt_drop", {48'd0, drop_count}, 64'd4);
      check("filt_beats", rx_q.size(), 0);
      check("filt_hdr_pulses", hdr_cnt - hdr_base, 0);
      check("filt_ip_src_held", {32'd0, ip_src}, 64'hC0A8_0001);

      // Broadcast destination with a different source address.
      rx_q.delete(); hdr_base = hdr_cnt;
      load_p(); pkt[5] = 32'hC0A8_0009; pkt[6] = 32'hFFFF_FFFF; pkt[4] = 32'h8011_7A1B;
      send_frame(10, 1'b1); idle(6);
      check("bcast_hdr_pulses", hdr_cnt - hdr_base, 1);
      check("bcast_ip_src", {32'd0, ip_src}, 64'hC0A8_0009);
      check_payload("bcast");

      // Short frames: TLAST on w4, then TLAST on w6, then a clean packet.
      rx_q.delete(); hdr_base = hdr_cnt;
      load_p(); send_frame(5, 1'b1); idle(2);
      check("short5_drop", {48'd0, drop_count}, 64'd5);
      send_frame(7, 1'b1); idle(2);
      check("short7_drop", {48'd0, drop_count}, 64'd6);
      send_frame(10, 1'b1); idle(6);
      check("short_next_hdr_pulses", hdr_cnt - hdr_base, 1);
      check("short_next_ip_src", {32'd0, ip_src}, 64'hC0A8_0001);
      check_payload("short_next");

      // Backpressure on the output.
      rx_q.delete(); bp_en = 1'b1;
      send_frame(10, 1'b1); idle(20);
      bp_en = 1'b0; idle(2);
      check_payload("bp");
      check("bp_stall_stable", stall_viol, 0);
      check("bp_ready_rule", ready_viol, 0);
      check("bp_drop", {48'd0, drop_count}, 64'd6);

      // Reset after w8 is accepted.
      load_p(); send_frame(9, 1'b0);
      check("rst_mid_pre_valid", {63'd0, m_valid}, 64'd1);
      rst = 1'b1; #1;
      check("rst_mid_m_valid", {63'd0, m_valid}, 64'd0);
      check("rst_mid_m_last", {63'd0, m_last}, 64'd0);
      check("rst_mid_s_ready", {63'd0, s_ready}, 64'd0);
      check("rst_mid_drop", {48'd0, drop_count}, 64'd0);
      check("rst_mid_ip_src", {32'd0, ip_src}, 64'd0);
      @(negedge clk); rst = 1'b0; idle(2);
      rx_q.delete(); hdr_base = hdr_cnt;
      send_frame(10, 1'b1); idle(6);
      check("post_rst_hdr_pulses", hdr_cnt - hdr_base, 1);
      check("post_rst_enet_src", {16'd0, enet_src}, 64'h0200_0000_0001);
      check("post_rst_pkt_id", {48'd0, pkt_id}, 64'h0001);
      check_payload("post_rst");
      check("post_rst_drop", {48'd0, drop_count}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
